// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared widths and FSM state type for the cacheline adaptor
package cacheline_adaptor_pkg;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = LINE_W / BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - bridges whole-line cache requests to 4-beat memory bursts
module cacheline_adaptor #(
  parameter int LINE_W = cacheline_adaptor_pkg::LINE_W,
  parameter int BEAT_W = cacheline_adaptor_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  output logic [31:0]       address_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  import cacheline_adaptor_pkg::*;

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFE0;
  localparam logic [1:0]  LAST_BEAT = 2'(BEATS - 1);

  state_e            r_state;
  logic [1:0]        r_cnt;
  logic [31:0]       r_addr;
  logic [LINE_W-1:0] r_wline;
  logic [LINE_W-1:0] r_rline;
  logic              r_read;
  logic              r_write;
  logic              r_resp;
  logic [BEAT_W-1:0] w_wbeat;

  assign w_wbeat   = r_wline[BEAT_W*int'(r_cnt) +: BEAT_W];
  // Write data only appears on the bus while a write burst is in flight.
  assign burst_o   = r_write ? w_wbeat : '0;
  assign line_o    = r_rline;
  assign address_o = r_addr;
  assign read_o    = r_read;
  assign write_o   = r_write;
  assign resp_o    = r_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rline <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (read_i) begin
            r_state <= ST_READ;
            r_addr  <= address_i & ADDR_MASK;
            r_read  <= 1'b1;
          end else if (write_i) begin
            r_state <= ST_WRITE;
            r_addr  <= address_i & ADDR_MASK;
            r_wline <= line_i;
            r_write <= 1'b1;
          end
        end
        ST_READ: begin
          if (resp_i) begin
            r_rline[BEAT_W*int'(r_cnt) +: BEAT_W] <= burst_i;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == LAST_BEAT) begin
              r_state <= ST_DONE;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (resp_i) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == LAST_BEAT) begin
              r_state <= ST_DONE;
              r_write <= 1'b0;
              r_resp  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_resp  <= 1'b0;
          r_addr  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_fail   = 0;

  cacheline_adaptor #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk(clk), .rst(rst),
    .address_i(address_i), .line_i(line_i), .line_o(line_o),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .address_o(address_o), .burst_i(burst_i), .burst_o(burst_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  // Memory-side responder for a read: pattern bits gate resp_i while read_o is high.
  task automatic do_read(input logic [31:0] addr, input logic both, input logic [7:0] pat,
                         input int plen, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3,
                         output int lat, output int nresp, output logic [31:0] addr_seen,
                         output logic wr_seen);
    logic [63:0] beats [4];
    int bi;
    int pi;
    logic acc;
    logic done;
    beats = '{b0, b1, b2, b3};
    bi = 0; pi = 0; lat = 0; nresp = 0; addr_seen = '0; wr_seen = 1'b0; done = 1'b0;
    read_i = 1'b1; write_i = both; address_i = addr; resp_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (read_o) begin
        resp_i = (pi < plen) ? pat[pi] : 1'b1;
        pi++;
      end else begin
        resp_i = 1'b0;
      end
      burst_i = beats[bi[1:0]];
      acc = read_o & resp_i;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (c == 0) address_i = 32'hFFFF_FFFF;
      if (acc) bi++;
      if (write_o) wr_seen = 1'b1;
      if (read_o) addr_seen = address_o;
      if (resp_o) begin
        nresp++;
        done = 1'b1;
      end
    end
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_o) nresp++;
      if (write_o) wr_seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL reset_read_o: got %b expected 0", read_o); end
    n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL reset_write_o: got %b expected 0", write_o); end
    n_checks++; if (resp_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_o: got %b expected 0", resp_o); end
    n_checks++; if (address_o !== 32'h0) begin n_fail++; $display("FAIL reset_address_o: got %h expected 0", address_o); end
    n_checks++; if (burst_o !== 64'h0) begin n_fail++; $display("FAIL reset_burst_o: got %h expected 0", burst_o); end
    n_checks++; if (line_o !== 256'h0) begin n_fail++; $display("FAIL reset_line_o: got %h expected 0", line_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int lat; int nresp; logic [31:0] a; logic w;
    do_read(32'h0000_1234, 1'b0, 8'hFF, 8,
            64'h1111111111111111, 64'h2222222222222222,
            64'h3333333333333333, 64'h4444444444444444, lat, nresp, a, w);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL read_latency: got %0d edges expected 5 (resp_o in cycle 6)", lat); end
    n_checks++; if (a !== 32'h0000_1220) begin n_fail++; $display("FAIL read_address_o: got %h expected 00001220", a); end
    n_checks++; if (line_o !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
      n_fail++; $display("FAIL read_line_o: got %h", line_o); end
    n_checks++; if (nresp !== 1) begin n_fail++; $display("FAIL read_resp_count: got %0d expected 1", nresp); end
  endtask

  task automatic test_write();
    logic [255:0] ln;
    logic [255:0] got;
    logic acc; logic done; logic wlow;
    int wi; int lat; int nresp;
    ln = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
    got = '0; wi = 0; lat = 0; nresp = 0; done = 1'b0; wlow = 1'b0;
    write_i = 1'b1; line_i = ln; address_i = 32'h0000_8040; resp_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      resp_i = write_o;
      acc = write_o;
      if (acc && wi < 4) got[64*wi +: 64] = burst_o;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (c == 0) line_i = ~ln;
      if (acc) wi++;
      if (resp_o) begin
        nresp++;
        done = 1'b1;
        wlow = !write_o;
      end
    end
    write_i = 1'b0; resp_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_o) nresp++;
    end
    n_checks++; if (got[63:0] !== 64'hAAAAAAAAAAAAAAAA) begin n_fail++; $display("FAIL write_beat0: got %h expected AAAAAAAAAAAAAAAA", got[63:0]); end
    n_checks++; if (got[127:64] !== 64'hBBBBBBBBBBBBBBBB) begin n_fail++; $display("FAIL write_beat1: got %h expected BBBBBBBBBBBBBBBB", got[127:64]); end
    n_checks++; if (got[191:128] !== 64'hCCCCCCCCCCCCCCCC) begin n_fail++; $display("FAIL write_beat2: got %h expected CCCCCCCCCCCCCCCC", got[191:128]); end
    n_checks++; if (got[255:192] !== 64'hDDDDDDDDDDDDDDDD) begin n_fail++; $display("FAIL write_beat3: got %h expected DDDDDDDDDDDDDDDD", got[255:192]); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL write_latency: got %0d expected 5", lat); end
    n_checks++; if (wlow !== 1'b1) begin n_fail++; $display("FAIL write_o_drop: got %b expected 1", wlow); end
    n_checks++; if (nresp !== 1) begin n_fail++; $display("FAIL write_resp_count: got %0d expected 1", nresp); end
    n_checks++; if (burst_o !== 64'h0) begin n_fail++; $display("FAIL write_burst_idle: got %h expected 0", burst_o); end
    n_checks++; if (line_o !== 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111) begin
      n_fail++; $display("FAIL write_line_o_kept: got %h", line_o); end
  endtask

  task automatic test_gapped_read();
    int lat; int nresp; logic [31:0] a; logic w;
    do_read(32'h0000_0040, 1'b0, 8'b0101_1001, 7,
            64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
            64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, lat, nresp, a, w);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL gap_latency: got %0d expected 8", lat); end
    n_checks++; if (line_o !== 256'hF0F0F0F0F0F0F0F0_0F0F0F0F0F0F0F0F_FEDCBA9876543210_0123456789ABCDEF) begin
      n_fail++; $display("FAIL gap_line_o: got %h", line_o); end
    n_checks++; if (nresp !== 1) begin n_fail++; $display("FAIL gap_resp_count: got %0d expected 1", nresp); end
  endtask

  task automatic test_simultaneous();
    int lat; int nresp; logic [31:0] a; logic w;
    line_i = {4{64'hBAD0BAD0BAD0BAD0}};
    do_read(32'h0000_0FFF, 1'b1, 8'hFF, 8,
            64'h5555555555555555, 64'h6666666666666666,
            64'h7777777777777777, 64'h8888888888888888, lat, nresp, a, w);
    n_checks++; if (w !== 1'b0) begin n_fail++; $display("FAIL both_write_o: got %b expected 0", w); end
    n_checks++; if (a !== 32'h0000_0FE0) begin n_fail++; $display("FAIL both_address_o: got %h expected 00000FE0", a); end
    n_checks++; if (line_o !== 256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555) begin
      n_fail++; $display("FAIL both_line_o: got %h", line_o); end
    n_checks++; if (nresp !== 1) begin n_fail++; $display("FAIL both_resp_count: got %0d expected 1", nresp); end
  endtask

  task automatic test_stray_resp();
    int nresp;
    nresp = 0;
    resp_i = 1'b1; burst_i = 64'hDEADDEADDEADDEAD;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_o) nresp++;
    end
    resp_i = 1'b0;
    n_checks++; if (nresp !== 0) begin n_fail++; $display("FAIL stray_resp_o: got %0d pulses expected 0", nresp); end
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL stray_read_o: got %b expected 0", read_o); end
    n_checks++; if (address_o !== 32'h0) begin n_fail++; $display("FAIL stray_address_o: got %h expected 0", address_o); end
    n_checks++; if (line_o !== 256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555) begin
      n_fail++; $display("FAIL stray_line_o: got %h", line_o); end
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] rb [4];
    rb = '{64'h9999999999999999, 64'h13579BDF2468ACE0, 64'hCAFEF00DDEADBEEF, 64'h00000000FFFFFFFF};
    read_i = 1'b1; address_i = 32'h0000_ABCD; resp_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      resp_i = 1'b1;
      burst_i = 64'hEEEE0000EEEE0000 + 64'(b);
      @(posedge clk);
      @(negedge clk);
    end
    resp_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL midrst_read_o: got %b expected 0", read_o); end
    n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL midrst_write_o: got %b expected 0", write_o); end
    n_checks++; if (resp_o !== 1'b0) begin n_fail++; $display("FAIL midrst_resp_o: got %b expected 0", resp_o); end
    n_checks++; if (address_o !== 32'h0) begin n_fail++; $display("FAIL midrst_address_o: got %h expected 0", address_o); end
    n_checks++; if (burst_o !== 64'h0) begin n_fail++; $display("FAIL midrst_burst_o: got %h expected 0", burst_o); end
    n_checks++; if (line_o !== 256'h0) begin n_fail++; $display("FAIL midrst_line_o: got %h expected 0", line_o); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (read_o !== 1'b1) begin n_fail++; $display("FAIL restart_read_o: got %b expected 1", read_o); end
    n_checks++; if (address_o !== 32'h0000_ABC0) begin n_fail++; $display("FAIL restart_address_o: got %h expected 0000ABC0", address_o); end
    resp_i = 1'b1; burst_i = rb[0];
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (line_o !== {192'h0, 64'h9999999999999999}) begin
      n_fail++; $display("FAIL restart_beat0: got %h", line_o); end
    for (int b = 1; b < 4; b++) begin
      burst_i = rb[b];
      @(posedge clk);
      @(negedge clk);
    end
    resp_i = 1'b0; read_i = 1'b0;
    n_checks++; if (resp_o !== 1'b1) begin n_fail++; $display("FAIL restart_resp_o: got %b expected 1", resp_o); end
    n_checks++; if (line_o !== 256'h00000000FFFFFFFF_CAFEF00DDEADBEEF_13579BDF2468ACE0_9999999999999999) begin
      n_fail++; $display("FAIL restart_line_o: got %h", line_o); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_gapped_read();
    test_simultaneous();
    test_stray_resp();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter: LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter: BEAT_W, default 64, memory burst beat width in bits; LINE_W/BEAT_W = 4 beats.
REQ-003 SHALL run on one clock, with asynchronous active-high reset (decided):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL provide these cache-side (responder) ports:
- address_i  in  32  line request address.
- line_i  in  LINE_W  write line data.
- line_o  out  LINE_W  read line data.
- read_i  in  1  line read request, held until resp_o.
- write_i  in  1  line write request, held until resp_o.
- resp_o  out  1  one-cycle transaction-complete pulse.
REQ-005 SHALL provide these memory-side (burst initiator) ports:
- address_o  out  32  line-aligned burst address.
- burst_i  in  BEAT_W  read beat data.
- burst_o  out  BEAT_W  write beat data.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  beat accepted/valid.

Function
REQ-006 SHALL implement FSM states IDLE, READ, WRITE, DONE with a 2-bit beat counter.
REQ-007 IDLE: read_i high -> latch address and go to READ; else write_i high -> latch address and line_i, go to WRITE; read_i and write_i both high -> read wins.
REQ-008 address_o SHALL equal {latched address[31:5], 5'b0} throughout READ/WRITE; it SHALL be 0 in IDLE.
REQ-009 READ: read_o held high; each cycle with resp_i high stores burst_i into line_o[BEAT_W*k +: BEAT_W], k = beat counter, then increments k.
REQ-010 READ: the cycle resp_i accepts beat 3 SHALL move the FSM to DONE; read_o SHALL be low from the next cycle.
REQ-011 WRITE: write_o held high; burst_o = latched line[BEAT_W*k +: BEAT_W]; each resp_i high increments k; beat-3 acceptance moves the FSM to DONE.
REQ-012 resp_i low cycles (gaps) inside READ/WRITE SHALL stall the counter without losing data.
REQ-013 DONE: resp_o SHALL be high for exactly one cycle, then the FSM returns to IDLE; a new request is accepted from the following IDLE cycle (minimum 1 idle cycle between transactions).
REQ-014 read_i, write_i, address_i and line_i changes after acceptance SHALL be ignored until IDLE.
REQ-015 resp_i high in IDLE or DONE SHALL be ignored (no state, counter or data change).
REQ-016 line_o SHALL hold the last completed read line until overwritten beat-by-beat by the next read; a write SHALL NOT modify line_o.
REQ-017 The beat counter SHALL wrap 3 -> 0 on the final beat; k SHALL be 0 on entry to READ/WRITE.
REQ-018 Read latency SHALL be (cycles to 4th resp_i) + 1 to resp_o; with back-to-back resp_i this is 6 cycles from the request edge.

Reset
REQ-019 rst high SHALL immediately force IDLE, k=0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0, including mid-transaction.
REQ-020 After rst deasserts, a still-high read_i/write_i SHALL start a fresh transaction at beat 0.

Structure
REQ-021 A shared package cacheline_adaptor_pkg SHALL hold LINE_W, BEAT_W, BEATS=4 and the state enum.
REQ-022 The block SHALL be a single module; no sub-module is required.

Verification
REQ-023 Read, back-to-back resp_i: address_i=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o pulse in cycle 6.
REQ-024 Write: line_i=0xDDDD..CCCC..BBBB..AAAA -> burst_o AAAA.., BBBB.., CCCC.., DDDD.. on successive resp_i; write_o drops after beat 3; single resp_o.
REQ-025 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> correct line assembled; resp_o exactly once, after the 4th resp_i.
REQ-026 Simultaneous read_i=write_i=1 -> read_o asserted, write_o never asserted.
REQ-027 rst asserted after beat 2 of a read -> all outputs 0 in the same cycle; retained read_i then restarts with beat 0 at the same address.
REQ-028 Stray resp_i in IDLE -> no resp_o, line_o unchanged.
